// File: rtl/bus_sched.sv
// Frame-buffer port scheduler: shares one burst memory port between the camera write FIFO and
// the display read FIFO, one command at a time, with a wrapping frame offset per client.
module bus_sched #(
  parameter int unsigned BURST_LEN      = 16,
  parameter int unsigned FIFO_DEPTH     = 512,
  parameter int unsigned WR_FRAME_WORDS = 77924,
  parameter int unsigned RD_FRAME_WORDS = 76800,
  parameter int unsigned WR_BASE        = 0,
  parameter int unsigned RD_BASE        = 0,
  parameter int unsigned LOW_WM         = 64,
  parameter int unsigned ADDR_W         = 24
) (
  input  logic              ctrl_clk,
  input  logic              reset_n,
  input  logic              read_init,
  input  logic [8:0]        write_fifo_rdusedw,
  input  logic [8:0]        read_fifo_wrusedw,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [4:0]        mem_len,
  input  logic              mem_ack,
  input  logic              mem_beat,
  output logic              wr_fifo_rdreq,
  output logic              rd_fifo_wrreq,
  output logic              wr_frame_done,
  output logic              rd_frame_done,
  output logic              busy
);

  localparam int unsigned MAX_FRAME =
      (WR_FRAME_WORDS > RD_FRAME_WORDS) ? WR_FRAME_WORDS : RD_FRAME_WORDS;
  localparam int unsigned OFF_W = $clog2(MAX_FRAME + 1);

  typedef enum logic [1:0] {StIdle, StReq, StBurst} state_e;

  state_e            r_state, w_state_next;
  logic [OFF_W-1:0]  r_wr_off, r_rd_off;
  logic [OFF_W-1:0]  w_wr_rem, w_rd_rem, w_wr_off_sum, w_rd_off_sum;
  logic [4:0]        w_wr_len, w_rd_len, r_beat_cnt;
  logic [9:0]        w_rd_fill;
  logic              w_wr_elig, w_rd_elig, w_rd_urgent;
  logic              w_grant_wr, w_grant_rd, w_last_beat;
  logic              r_read_active, r_last_grant_wr;
  logic              r_mem_req, r_mem_we, r_busy, r_wr_frame_done, r_rd_frame_done;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [4:0]        r_mem_len;

  // Burst length is clipped to what is left of the frame, so the last burst is partial.
  always_comb begin
    w_wr_rem = OFF_W'(WR_FRAME_WORDS) - r_wr_off;
    w_rd_rem = OFF_W'(RD_FRAME_WORDS) - r_rd_off;
    w_wr_len = (w_wr_rem >= OFF_W'(BURST_LEN)) ? 5'(BURST_LEN) : w_wr_rem[4:0];
    w_rd_len = (w_rd_rem >= OFF_W'(BURST_LEN)) ? 5'(BURST_LEN) : w_rd_rem[4:0];
    w_rd_fill   = {1'b0, read_fifo_wrusedw} + {5'd0, w_rd_len};
    w_wr_elig   = write_fifo_rdusedw >= {4'd0, w_wr_len};
    w_rd_elig   = r_read_active && (w_rd_fill <= 10'(FIFO_DEPTH - 1));
    w_rd_urgent = {1'b0, read_fifo_wrusedw} < 10'(LOW_WM);
    w_wr_off_sum = r_wr_off + OFF_W'(r_mem_len);
    w_rd_off_sum = r_rd_off + OFF_W'(r_mem_len);
  end

  always_comb begin
    w_grant_wr = 1'b0;
    w_grant_rd = 1'b0;
    if (r_state == StIdle) begin
      if (w_wr_elig && w_rd_elig) begin
        if (w_rd_urgent || r_last_grant_wr) w_grant_rd = 1'b1;
        else                                w_grant_wr = 1'b1;
      end else if (w_wr_elig) begin
        w_grant_wr = 1'b1;
      end else if (w_rd_elig) begin
        w_grant_rd = 1'b1;
      end
    end
  end

  assign w_last_beat = (r_state == StBurst) && mem_beat && (r_beat_cnt == r_mem_len - 5'd1);

  always_ff @(posedge ctrl_clk or negedge reset_n) begin
    if (!reset_n) r_state <= StIdle;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (w_grant_wr || w_grant_rd) w_state_next = StReq;
      StReq:   if (mem_ack) w_state_next = StBurst;
      StBurst: if (w_last_beat) w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // FIFO strobes follow mem_beat combinationally; gated by state so reset kills them at once.
  always_comb begin
    wr_fifo_rdreq = 1'b0;
    rd_fifo_wrreq = 1'b0;
    if (r_state == StBurst) begin
      wr_fifo_rdreq = mem_beat & r_mem_we;
      rd_fifo_wrreq = mem_beat & ~r_mem_we;
    end
  end

  always_ff @(posedge ctrl_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_off        <= '0;
      r_rd_off        <= '0;
      r_beat_cnt      <= '0;
      r_read_active   <= 1'b0;
      r_last_grant_wr <= 1'b0;
      r_mem_req       <= 1'b0;
      r_mem_we        <= 1'b0;
      r_mem_addr      <= '0;
      r_mem_len       <= '0;
      r_busy          <= 1'b0;
      r_wr_frame_done <= 1'b0;
      r_rd_frame_done <= 1'b0;
    end else begin
      r_mem_req       <= (w_state_next == StReq);
      r_busy          <= (w_state_next != StIdle);
      r_wr_frame_done <= 1'b0;
      r_rd_frame_done <= 1'b0;
      if (read_init) r_read_active <= 1'b1;

      if (w_grant_wr) begin
        r_mem_we   <= 1'b1;
        r_mem_addr <= ADDR_W'(WR_BASE) + ADDR_W'(r_wr_off);
        r_mem_len  <= w_wr_len;
      end else if (w_grant_rd) begin
        r_mem_we   <= 1'b0;
        r_mem_addr <= ADDR_W'(RD_BASE) + ADDR_W'(r_rd_off);
        r_mem_len  <= w_rd_len;
      end

      if (r_state == StReq && mem_ack)         r_beat_cnt <= '0;
      else if (r_state == StBurst && mem_beat) r_beat_cnt <= r_beat_cnt + 5'd1;

      if (w_last_beat) begin
        r_last_grant_wr <= r_mem_we;
        if (r_mem_we) begin
          if (w_wr_off_sum == OFF_W'(WR_FRAME_WORDS)) begin
            r_wr_off        <= '0;
            r_wr_frame_done <= 1'b1;
          end else begin
            r_wr_off <= w_wr_off_sum;
          end
        end else begin
          if (w_rd_off_sum == OFF_W'(RD_FRAME_WORDS)) begin
            r_rd_off        <= '0;
            r_rd_frame_done <= 1'b1;
          end else begin
            r_rd_off <= w_rd_off_sum;
          end
        end
      end
    end
  end

  assign mem_req       = r_mem_req;
  assign mem_we        = r_mem_we;
  assign mem_addr      = r_mem_addr;
  assign mem_len       = r_mem_len;
  assign busy          = r_busy;
  assign wr_frame_done = r_wr_frame_done;
  assign rd_frame_done = r_rd_frame_done;

endmodule

// File: tb/tb_bus_sched.sv
// Bench for bus_sched: directed scenarios plus randomized traffic, all checked every cycle
// against a transaction-level model of the scheduler.
module tb_bus_sched;

  // Short frames keep the wrap scenario fast; 644 % 16 == 4, like the full 77924-word frame.
  localparam int unsigned BL    = 16;
  localparam int unsigned DEPTH = 512;
  localparam int unsigned WRF   = 644;
  localparam int unsigned RDF   = 640;
  localparam int unsigned WRB   = 0;
  localparam int unsigned RDB   = 'h2_0000;
  localparam int unsigned LWM   = 64;
  localparam int unsigned AW    = 24;

  logic          ctrl_clk = 1'b0;
  logic          reset_n, read_init, mem_ack, mem_beat;
  logic [8:0]    wfifo, rfifo;
  logic          mem_req, mem_we, wr_fifo_rdreq, rd_fifo_wrreq, wr_frame_done, rd_frame_done;
  logic          busy;
  logic [AW-1:0] mem_addr;
  logic [4:0]    mem_len;

  always #5 ctrl_clk = ~ctrl_clk;

  bus_sched #(
    .BURST_LEN(BL), .FIFO_DEPTH(DEPTH), .WR_FRAME_WORDS(WRF), .RD_FRAME_WORDS(RDF),
    .WR_BASE(WRB), .RD_BASE(RDB), .LOW_WM(LWM), .ADDR_W(AW)
  ) dut (
    .ctrl_clk(ctrl_clk), .reset_n(reset_n), .read_init(read_init),
    .write_fifo_rdusedw(wfifo), .read_fifo_wrusedw(rfifo),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_len(mem_len),
    .mem_ack(mem_ack), .mem_beat(mem_beat),
    .wr_fifo_rdreq(wr_fifo_rdreq), .rd_fifo_wrreq(rd_fifo_wrreq),
    .wr_frame_done(wr_frame_done), .rd_frame_done(rd_frame_done), .busy(busy)
  );

  int n_vec = 0, n_err = 0;
  int n_wpop = 0, n_wdone = 0, n_rdone = 0;
  int mem_mode = 1;  // 0 random memory, 1 full speed, 2 never acks

  // Model: current transaction (phase 0 none, 1 command posted, 2 data moving) plus frame state.
  int          m_phase, m_len, m_left, m_wr_off, m_rd_off;
  int unsigned m_addr;
  bit          m_we, m_ract, m_last_wr, m_wdone, m_rdone;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_len = 0; m_left = 0; m_wr_off = 0; m_rd_off = 0; m_addr = 0;
    m_we = 0; m_ract = 0; m_last_wr = 0; m_wdone = 0; m_rdone = 0;
  endtask

  task automatic model_step();
    int wl, rl;
    bit w_ok, r_ok, pick_rd;
    if (!reset_n) begin
      model_reset();
      return;
    end
    m_wdone = 0;
    m_rdone = 0;
    if (m_phase == 0) begin
      wl = (int'(WRF) - m_wr_off < int'(BL)) ? int'(WRF) - m_wr_off : int'(BL);
      rl = (int'(RDF) - m_rd_off < int'(BL)) ? int'(RDF) - m_rd_off : int'(BL);
      w_ok = int'(wfifo) >= wl;
      r_ok = m_ract && (int'(rfifo) + rl < int'(DEPTH));
      if (w_ok || r_ok) begin
        if (w_ok && r_ok) pick_rd = (int'(rfifo) < int'(LWM)) || m_last_wr;
        else              pick_rd = r_ok;
        m_we    = !pick_rd;
        m_len   = pick_rd ? rl : wl;
        m_addr  = pick_rd ? RDB + m_rd_off : WRB + m_wr_off;
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      if (mem_ack) begin
        m_phase = 2;
        m_left  = m_len;
      end
    end else if (mem_beat) begin
      m_left--;
      if (m_left == 0) begin
        if (m_we) begin
          m_wr_off = (m_wr_off + m_len) % int'(WRF);
          m_wdone  = (m_wr_off == 0);
        end else begin
          m_rd_off = (m_rd_off + m_len) % int'(RDF);
          m_rdone  = (m_rd_off == 0);
        end
        m_last_wr = m_we;
        m_phase   = 0;
      end
    end
    if (read_init) m_ract = 1;
  endtask

  task automatic check_outputs();
    cmp("mem_req", mem_req, m_phase == 1);
    cmp("busy", busy, m_phase != 0);
    cmp("wr_fifo_rdreq", wr_fifo_rdreq, (m_phase == 2) && mem_beat && m_we);
    cmp("rd_fifo_wrreq", rd_fifo_wrreq, (m_phase == 2) && mem_beat && !m_we);
    cmp("wr_frame_done", wr_frame_done, m_wdone);
    cmp("rd_frame_done", rd_frame_done, m_rdone);
    if (m_phase == 1) begin
      cmp("mem_we", mem_we, m_we);
      cmp("mem_addr", mem_addr, m_addr);
      cmp("mem_len", mem_len, m_len);
    end
    if (wr_fifo_rdreq === 1'b1) n_wpop++;
    if (wr_frame_done === 1'b1) n_wdone++;
    if (rd_frame_done === 1'b1) n_rdone++;
  endtask

  task automatic drive_memory();
    mem_ack  = 1'b0;
    mem_beat = 1'b0;
    if (m_phase == 1 && mem_mode != 2) mem_ack = (mem_mode == 1) || ($urandom_range(0, 2) == 0);
    if (m_phase == 2) mem_beat = (mem_mode == 1) || ($urandom_range(0, 3) != 0);
  endtask

  // One cycle: check at the falling edge, let the model absorb the rising edge, then drive.
  task automatic tick();
    @(negedge ctrl_clk);
    check_outputs();
    @(posedge ctrl_clk);
    model_step();
    #1;
    drive_memory();
  endtask

  task automatic wait_req(input int limit, input string what);
    int n = 0;
    while (mem_req !== 1'b1 && n < limit) begin
      tick();
      n++;
    end
    n_vec++;
    if (mem_req !== 1'b1) begin
      n_err++;
      $display("FAIL %s: mem_req still %b after %0d cycles, required 1", what, mem_req, n);
    end
  endtask

  task automatic wait_idle(input int limit, input string what);
    int n = 0;
    while (busy !== 1'b0 && n < limit) begin
      tick();
      n++;
    end
    n_vec++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL %s: busy still %b after %0d cycles, required 0", what, busy, n);
    end
  endtask

  initial begin
    logic [3:0] seq;
    bit         found;
    int         n;
    reset_n = 1'b1; read_init = 1'b0; wfifo = '0; rfifo = '0;
    mem_ack = 1'b0; mem_beat = 1'b0;
    model_reset();
    #1 reset_n = 1'b0;
    #1;
    cmp("reset mem_req", mem_req, 0);
    cmp("reset mem_we", mem_we, 0);
    cmp("reset mem_addr", mem_addr, 0);
    cmp("reset mem_len", mem_len, 0);
    cmp("reset busy", busy, 0);
    cmp("reset wr_frame_done", wr_frame_done, 0);
    repeat (3) tick();
    reset_n = 1'b1;

    // First write grant with the memory stalled, then a full-speed burst.
    mem_mode = 2;
    wfifo = 9'd16;
    wait_req(2, "first write grant");
    cmp("first grant we", mem_we, 1);
    cmp("first grant addr", mem_addr, WRB);
    cmp("first grant len", mem_len, 16);
    repeat (3) tick();
    cmp("req held while unacked", mem_req, 1);
    n_wpop = 0;
    mem_mode = 1;
    wait_idle(40, "first burst");
    wait_req(4, "second write grant");
    cmp("pops in first burst", n_wpop, 16);
    cmp("second grant addr", mem_addr, WRB + 16);

    // 15 words is one short of a full burst.
    wfifo = 9'd15;
    wait_idle(40, "second burst");
    repeat (8) tick();
    cmp("no grant at 15 words", mem_req, 0);
    wfifo = 9'd16;
    wait_req(2, "grant at 16 words");
    cmp("third grant addr", mem_addr, WRB + 32);

    // Stream writes up to the partial last burst of the frame.
    wfifo = 9'd300;
    found = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      wait_idle(40, "write stream");
      wait_req(4, "write stream grant");
      if (mem_addr == AW'(WRB + WRF - 4)) found = 1;
    end
    cmp("last burst addr", mem_addr, WRB + WRF - 4);
    cmp("last burst len", mem_len, 4);
    n_wdone = 0;
    wait_idle(40, "last burst");
    wait_req(4, "grant after wrap");
    cmp("wr_frame_done pulses", n_wdone, 1);
    cmp("addr after wrap", mem_addr, WRB);

    // Read client: blocked at 496, granted at 495.
    wfifo = 9'd0;
    wait_idle(40, "drain writes");
    read_init = 1'b1;
    rfifo = 9'd496;
    tick();
    read_init = 1'b0;
    repeat (6) tick();
    cmp("no read at 496", mem_req, 0);
    rfifo = 9'd495;
    wait_req(2, "read grant at 495");
    cmp("read grant we", mem_we, 0);
    cmp("read grant addr", mem_addr, RDB);

    // Ties alternate starting with WRITE after a read; an urgent read FIFO wins every tie.
    rfifo = 9'd100;
    wfifo = 9'd300;
    seq = '0;
    for (int i = 0; i < 4; i++) begin
      wait_idle(40, "alternate burst");
      wait_req(4, "alternate grant");
      seq = {seq[2:0], mem_we};
    end
    cmp("alternating grants W,R,W,R", seq, 4'b1010);
    rfifo = 9'd10;
    seq = '1;
    for (int i = 0; i < 3; i++) begin
      wait_idle(40, "urgent burst");
      wait_req(4, "urgent grant");
      seq = {seq[2:0], mem_we};
    end
    cmp("urgent reads win ties", seq[2:0], 3'b000);

    // Reset five beats into a write burst.
    rfifo = 9'd500;
    wait_idle(40, "before reset test");
    wait_req(4, "write before reset");
    cmp("burst before reset is write", mem_we, 1);
    n_wpop = 0;
    n = 0;
    while (n_wpop < 5 && n < 40) begin
      tick();
      n++;
    end
    reset_n = 1'b0;
    model_reset();
    mem_beat = 1'b1;
    #1;
    cmp("async reset mem_req", mem_req, 0);
    cmp("async reset busy", busy, 0);
    cmp("async reset wr_fifo_rdreq", wr_fifo_rdreq, 0);
    cmp("async reset mem_addr", mem_addr, 0);
    cmp("async reset mem_len", mem_len, 0);
    cmp("async reset mem_we", mem_we, 0);
    repeat (2) tick();
    reset_n = 1'b1;
    wait_req(4, "grant after reset");
    cmp("addr after reset", mem_addr, WRB);

    // Randomized traffic against the model.
    mem_mode = 0;
    read_init = 1'b1;
    tick();
    read_init = 1'b0;
    n_rdone = 0;
    for (int i = 0; i < 5000; i++) begin
      if ($urandom_range(0, 3) == 0) wfifo = 9'($urandom_range(0, 63));
      if ($urandom_range(0, 3) == 0)
        rfifo = ($urandom_range(0, 3) == 0) ? 9'($urandom_range(0, 511)) : 9'($urandom_range(0, 100));
      if ($urandom_range(0, 99) == 0) read_init = 1'b1;
      else                            read_init = 1'b0;
      tick();
    end
    cmp("read frames completed", n_rdone != 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
